// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: 8-digit 7-segment scan driver with frame double-buffering and per-position blanking.
// Define FND_LZB_EN to enable leading-zero blanking of the shadow digits.
module fnd_scan_driver #(
   parameter int BLANK_CYC = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [2:0]  i_pos,
   input  logic [31:0] i_bcd,
   input  logic [7:0]  i_dp,
   input  logic        i_update,
   output logic [7:0]  o_com,
   output logic [7:0]  o_seg,
   output logic        o_frame
);
   typedef enum logic {BLANK, DRIVE} state_t;
   state_t      state_q, state_d;
   logic [2:0]  pos_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] stg_bcd_q, sh_bcd_q;
   logic [7:0]  stg_dp_q, sh_dp_q;
   logic        pend_q, frame_q;
   logic        chg, bnd;
   logic [8:0]  lz;

   assign chg = i_pos != pos_q;
   assign bnd = chg && i_pos == 3'd7;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // position, scan state and blank counter registers
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         pos_q   <= 3'd7;
         state_q <= BLANK;
         cnt_q   <= 8'(BLANK_CYC);
      end else begin
         pos_q   <= i_pos;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end

   // a position change (re)starts the blanking gap; the gap ends on the edge where cnt reaches 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (chg) begin
         state_d = (BLANK_CYC == 0) ? DRIVE : BLANK;
         cnt_d   = 8'(BLANK_CYC);
      end else if (state_q == BLANK) begin
         state_d = (cnt_q <= 8'd1) ? DRIVE : BLANK;
         cnt_d   = cnt_q - 8'd1;
      end
   end

   // staging captures every update; shadow only changes at the wrap to position 7
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         stg_bcd_q <= '0;
         stg_dp_q  <= '0;
         sh_bcd_q  <= '0;
         sh_dp_q   <= '0;
         pend_q    <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         if (i_update) begin
            stg_bcd_q <= i_bcd;
            stg_dp_q  <= i_dp;
         end
         if (bnd && i_update) begin
            sh_bcd_q <= i_bcd;
            sh_dp_q  <= i_dp;
         end else if (bnd && pend_q) begin
            sh_bcd_q <= stg_bcd_q;
            sh_dp_q  <= stg_dp_q;
         end
         pend_q  <= !bnd && (pend_q || i_update);
         frame_q <= bnd && (pend_q || i_update);
      end

`ifdef FND_LZB_EN
   // a digit blanks when it and every digit above it are zero; digit 0 always shows
   always_comb begin
      lz = 9'h100;
      for (int k = 7; k > 0; k--)
         lz[k] = (sh_bcd_q[4*k +: 4] == 4'h0) && lz[k+1];
   end
`else
   assign lz = 9'h100;
`endif

   // outputs decode only registered state, so i_pos never reaches the pins combinationally
   always_comb begin
      o_com   = (state_q == DRIVE) ? ~(8'b1 << pos_q) : 8'hFF;
      o_seg   = (state_q == DRIVE) ? {~sh_dp_q[pos_q], lz[pos_q] ? 7'h7F : glyph(sh_bcd_q[4*pos_q +: 4])} : 8'hFF;
      o_frame = frame_q;
   end
endmodule

// File: doc/fnd_scan_driver.md
# fnd_scan_driver

Consumer end of the digit-position scan for the multiplexed 8-digit 7-segment display in the digital clock. It takes the 3-bit position stream from the position shifter, which counts down 7 to 0 and wraps, and drives the matching common (digit enable) and segment lines. It double-buffers the displayed value so a frame never tears. It also inserts a blanking gap on every position change to suppress ghosting.

## Interface
- BLANK_CYC, 4: i_clk cycles of all-off output after each position change (0..255; 0 = no blanking).
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pos  in  3  current digit position, synchronous to i_clk, counts 7→0 then wraps to 7.
- i_bcd  in  32  eight hex/BCD nibbles; digit k at [4k+3:4k].
- i_dp  in  8  decimal points; bit k belongs to digit k; 1 = lit.
- i_update  in  1  one-cycle request to display i_bcd/i_dp from the next frame.
- o_com  out  8  digit enables, active-low, at most one bit low.
- o_seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- o_frame  out  1  one-cycle pulse: shadow buffer loaded.

## Operation
- Registers:
  - pos_q (3b);
  - state {BLANK, DRIVE};
  - cnt (8b);
  - staging buffer with pending flag;
  - shadow buffer (32b digits + 8b dp).
- Change detect: at each edge where i_pos != pos_q:
  - pos_q <= i_pos;
  - if BLANK_CYC==0, state <= DRIVE; else state <= BLANK and cnt <= BLANK_CYC.
- BLANK:
  - o_com=8'hFF, o_seg=8'hFF.
  - cnt decrements each edge; at the edge where cnt==1, state <= DRIVE.
  - A position change in BLANK reloads cnt, restarting the gap.
- DRIVE:
  - o_com = ~(8'b1 << pos_q).
  - o_seg = {~shadow_dp[pos_q], glyph(shadow digit pos_q)}.
  - Stays in DRIVE until the next change.
- glyph (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000;
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000;
  - 8=0000000, 9=0010000, A=0001000, b=0000011;
  - C=1000110, d=0100001, E=0000110, F=0001110.
- Update capture: i_update copies i_bcd/i_dp into staging and sets pending. If several updates arrive before a boundary, the last one wins.
- Frame boundary: a change edge whose new pos is 7.
  - If pending, shadow <= staging, pending cleared, and o_frame pulses.
  - If not pending, shadow holds and o_frame stays 0.
- i_update on the boundary edge: shadow loads i_bcd/i_dp directly, pending is cleared, o_frame pulses.
- Outputs are decoded from registered state only, with no combinational path from i_pos to outputs.

## Timing
- Reset values:
  - pos_q=7, state=BLANK, cnt=BLANK_CYC;
  - staging=0, shadow=0, pending=0;
  - o_com=8'hFF, o_seg=8'hFF, o_frame=0.
- Reset asserted mid-operation forces these values immediately (asynchronously).
- After reset release with i_pos==7 and no change, the blank counts down and DRIVE shows digit 7 of shadow (0).
- Change sampled at edge N: outputs blank from edge N through edge N+BLANK_CYC−1; digit driven from edge N+BLANK_CYC.
- o_frame is high for exactly the cycle following the boundary edge.
- New shadow data appears at the first DRIVE of position 7 after the load.

## Configuration
- FND_LZB_EN defined: leading-zero blanking on shadow.
  - Zero digits at positions above the highest nonzero digit show gfedcba=1111111.
  - Their dp is still driven from shadow_dp.
  - Digit 0 is never blanked; all-zero shows a single 0.
- Undefined: every digit shows its glyph.

## Test plan
- Reset mid-DRIVE → o_com=8'hFF, o_seg=8'hFF, o_frame=0 immediately; pending cleared.
- BLANK_CYC=4, update i_bcd=32'h76543210, i_dp=0, scan 7..0:
  - after the wrap to 7: 4 cycles of o_com=FF, then o_com=8'h7F, o_seg=8'hF8;
  - at pos 0: o_com=8'hFE, o_seg=8'hC0.
- Update with 32'h11111111 while pos=3 → positions 2..0 still show the old frame; at the next wrap to 7, o_frame pulses once and o_seg=8'hF9.
- Position change after 2 blank cycles → 4 further blank cycles before drive.
- i_update coincident with the boundary edge → new value is shown in that same frame; o_frame pulses once; pending=0 afterward.
- FND_LZB_EN with i_bcd=32'h00000120 → positions 7..3 o_seg=8'hFF, pos 0 o_seg=8'hC0. Without the macro, pos 7 o_seg=8'hC0.
